// File: rtl/seq_det_pkg.sv
// Shared types and default sizes for the serial pattern detector.
package seq_det_pkg;

    typedef enum logic {
        MODE_NONOVL = 1'b0,
        MODE_OVL    = 1'b1
    } mode_e;

    localparam int PAT_W_DEF = 4;
    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Latency: cnt/sat reflect an inc/clr one clock after it is sampled.
// Backpressure: none; inc is ignored once the counter is at all-ones.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         sat
);

    assign sat = &cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Moore detector for a programmable PAT_W-bit serial pattern with a saturating match count.
// Latency: z and match_cnt update on the edge that samples the completing bit.
// Backpressure: en gates sampling; with en low the history, fill and z all hold.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = PAT_W_DEF,
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b1001)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             w,
    input  logic             load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic             z,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    localparam int                FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  pat_reg;
    logic [PAT_W-1:0]  hist;
    logic [FILL_W-1:0] fill;

    logic [PAT_W-1:0]  hist_nxt;
    logic [FILL_W-1:0] fill_inc;
    logic              hit;
    mode_e             mode;

    assign mode     = mode_e'(overlap);
    assign hist_nxt = {hist[PAT_W-2:0], w};
    assign fill_inc = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
    // A hit needs a full window of accepted bits, so stale zeros in hist never match.
    assign hit      = en && !load && (fill_inc == FILL_FULL) && (hist_nxt == pat_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_reg <= PAT_RST;
            hist    <= '0;
            fill    <= '0;
            z       <= 1'b0;
        end else if (load) begin
            pat_reg <= pat_in;
            hist    <= '0;
            fill    <= '0;
            z       <= 1'b0;
        end else if (en) begin
            hist <= hist_nxt;
            z    <= hit;
            // Non-overlapping mode restarts the window so matched bits are not reused.
            fill <= (hit && mode == MODE_NONOVL) ? '0 : fill_inc;
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk(clk),
        .rst(rst),
        .inc(hit),
        .clr(clr_cnt),
        .cnt(match_cnt),
        .sat(cnt_sat)
    );

endmodule
